stepper_seq_driver: RTL
=======================

# stepper_seq_driver

Command-driven sequencer for a 4-coil unipolar stepper on the Pmod step driver header, successor to the fixed full-step driver. It accepts move commands (step count, direction, drive mode) over a valid/ready handshake, paces steps with a programmable period, tracks absolute position and reports completion. It sits between the motion-control logic and the coil output pins.

## Interface
- PERIOD_W, 20: width of the step period in clock cycles.
- COUNT_W, 16: width of the per-command step count.
- POS_W, 24: width of the two's-complement position counter.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable; 0 freezes step pacing, state held.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block can accept a command (high only in IDLE).
- cmd_dir  in  1  0 = forward (phase index +), 1 = reverse.
- cmd_steps  in  COUNT_W  number of steps to issue.
- cmd_mode  in  2  00 wave (1 coil), 01 two-phase full, 10 half-step, 11 treated as 10.
- period  in  PERIOD_W  clocks per step; 0 treated as 1.
- abort  in  1  terminate the running command.
- busy  out  1  command in progress (RUN or DWELL).
- done  out  1  one-cycle pulse at command end (normal, aborted or zero-length).
- position  out  POS_W  signed step position.
- signal  out  4  coil drive, registered.

## Operation
- Phase index idx 0..7; patterns: 0001,0011,0010,0110,0100,1100,1000,1001.
- Step size: half = ±1; wave targets even idx, two-phase targets odd idx: move ±1 if idx parity mismatches target, else ±2. Index wraps modulo 8.
- position += 1 (forward) / -= 1 (reverse) per step regardless of size; wraps modulo 2^POS_W.
- FSM IDLE -> RUN -> DWELL -> IDLE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready: latch dir, steps, mode, period (period sampled once). steps=0 -> stay IDLE, done pulse next cycle. Else -> RUN, signal=pattern(idx) next cycle.
- RUN: timer counts while en=1; on reaching P-1 it clears and one step is issued (idx, position, signal update same edge). After the N-th step -> DWELL.
- DWELL: holds final pattern one further period P (en-gated), then -> IDLE with done pulse.
- abort in RUN/DWELL: -> IDLE next edge, done pulse, no step that cycle (abort beats a coincident step).
- en=0: timer, idx, position frozen; signal held; abort still honoured; cmd acceptance in IDLE unaffected.
- cmd_valid during busy ignored (not queued).

## Timing
- Reset: state IDLE, idx=0, position=0, signal=0000, busy=0, done=0, cmd_ready=1 (first cycle after rst deasserts).
- Acceptance edge t0: busy=1 and signal=pattern(idx) from t0+1.
- Step k (1..N) visible from t0+1+k·P (en held high).
- done=1, busy=0, cmd_ready=1 in cycle starting t0+1+(N+1)·P; total busy (N+1)·P cycles.
- Zero-length command: done at t0+1, busy never asserted.
- Abort sampled at edge t: busy=0, done=1 from t+1; new command accepted at earliest at edge t+1.
- rst mid-command: immediate return to reset values, no done pulse.

## Configuration
- STEP_HOLD_EN defined: in IDLE (after done/abort) signal keeps the last pattern (holding torque).
- Not defined: signal = 0000 whenever state is IDLE, including the done cycle; idx remembered so next command re-energises at same phase.

## Structure
- Package stepper_pkg: mode enum (WAVE, TWO_PHASE, HALF), FSM state enum, 8-entry coil pattern constant, step-size function of (idx, mode, dir).
- Sub-module step_timer: en-gated period counter with load/clear, emits one-cycle tick at count P-1; instantiated once.

## Test plan
- Reset then half-step fwd, N=3, P=4: signal 0001@+1, 0011@+5, 0010@+9, 0110@+13, done@+17, position=3.
- Wave rev from idx=1, N=2, P=1: idx 1->0->6, signal 0001 then 1000, position=-2.
- Two-phase fwd N=4, en low for 10 cycles mid-run: pattern sequence 0011,0110,1100,1001,0011, done delayed exactly 10 cycles.
- Abort coinciding with step tick: no pattern change, done next cycle, cmd_ready=1, position unchanged.
- cmd_steps=0 and period=0: done at +1, busy stays 0; then N=2 with period=0 steps every cycle.
- Build with and without STEP_HOLD_EN: after done signal holds last pattern vs 0000; position wrap at 2^POS_W-1 +1 -> 0.

Source files
------------

// File: rtl/stepper_seq_driver_pkg.sv
// Shared types and helpers for the stepper command sequencer: drive modes,
// FSM states, the 8-entry half-step coil table and the phase step-size rule.
package stepper_pkg;

  typedef enum logic [1:0] {
    WAVE      = 2'd0,
    TWO_PHASE = 2'd1,
    HALF      = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DWELL = 2'd2
  } state_e;

  // Entry [i] is the coil pattern for phase index i (entry 0 in the LSBs).
  localparam logic [7:0][3:0] COIL_PATTERN = {
    4'b1001, 4'b1000, 4'b1100, 4'b0100,
    4'b0110, 4'b0010, 4'b0011, 4'b0001
  };

  function automatic logic [3:0] coil_pattern(input logic [2:0] idx);
    return COIL_PATTERN[idx];
  endfunction

  // Raw command encoding to drive mode; the spare code 11 runs as half-step.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    mode_e m;
    case (raw)
      2'b00:   m = WAVE;
      2'b01:   m = TWO_PHASE;
      default: m = HALF;
    endcase
    return m;
  endfunction

  // Modulo-8 increment applied to the phase index for one step.
  // Wave lands on even indices, two-phase on odd ones: a single index move
  // realigns a mismatched phase, otherwise the index moves by two.
  function automatic logic [2:0] step_delta(input logic [2:0] idx,
                                            input mode_e      mode,
                                            input logic       dir);
    logic [2:0] mag;
    case (mode)
      WAVE:      mag = idx[0] ? 3'd1 : 3'd2;
      TWO_PHASE: mag = idx[0] ? 3'd2 : 3'd1;
      HALF:      mag = 3'd1;
      default:   mag = 3'd1;
    endcase
    return dir ? (3'd0 - mag) : mag;
  endfunction

endpackage

// File: rtl/stepper_seq_driver_if.sv
// Move-command handshake between motion control (master) and the sequencer.
interface stepper_seq_driver_if #(
  parameter int COUNT_W = 16
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_dir;
  logic [COUNT_W-1:0] cmd_steps;
  logic [1:0]         cmd_mode;

  modport master (
    output cmd_valid, cmd_dir, cmd_steps, cmd_mode,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_steps, cmd_mode,
    output cmd_ready
  );
endinterface

// File: rtl/stepper_seq_driver_step_timer.sv
// Enable-gated step period counter. Counts 0..P-1 while run is high and
// flags the terminal count with a one-cycle tick; clr forces it back to 0.
module step_timer #(
  parameter int PERIOD_W = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                run,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  localparam logic [PERIOD_W-1:0] ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};

  logic [PERIOD_W-1:0] cnt_r;
  logic                at_end_s;

  // period is never zero here: the owner substitutes 1 when latching it
  assign at_end_s = (cnt_r == (period - ONE));
  assign tick     = run & at_end_s;

  // Period counter: wraps to zero on the tick, frozen while run is low
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (run) begin
      if (at_end_s) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + ONE;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/stepper_seq_driver.sv
// Command-driven 4-coil unipolar stepper sequencer. Accepts move commands
// over a valid/ready handshake, paces steps at a latched period, tracks a
// signed absolute position and pulses done at the end of every command.
// Build option STEP_HOLD_EN: when defined, the coils keep the last pattern
// while idle (holding torque); otherwise they are de-energised in IDLE.
module stepper_seq_driver
  import stepper_pkg::*;
#(
  parameter int PERIOD_W = 20,
  parameter int COUNT_W  = 16,
  parameter int POS_W    = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  stepper_seq_driver_if.slave  cmd,
  input  logic [PERIOD_W-1:0]  period,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [POS_W-1:0]     position,
  output logic [3:0]           signal
);

  localparam logic [PERIOD_W-1:0] PER_ONE   = {{(PERIOD_W-1){1'b0}}, 1'b1};
  localparam logic [COUNT_W-1:0]  STEP_ONE  = {{(COUNT_W-1){1'b0}}, 1'b1};
  localparam logic [POS_W-1:0]    POS_ONE   = {{(POS_W-1){1'b0}}, 1'b1};

  state_e              state_r, state_nxt_s;
  logic                dir_r;
  mode_e               mode_r;
  logic [COUNT_W-1:0]  steps_left_r;
  logic [PERIOD_W-1:0] period_r;
  logic [2:0]          idx_r, idx_nxt_s;
  logic [POS_W-1:0]    position_r, position_nxt_s;
  logic [3:0]          signal_r, signal_nxt_s;
  logic                done_r, done_nxt_s;
  logic                busy_r;
  logic                cmd_ready_r;

  logic                accept_s;
  logic                zero_len_s;
  logic                tick_s;
  logic                step_s;
  logic                last_step_s;
  logic                timer_clr_s;
  logic                timer_run_s;
  logic [2:0]          idx_stepped_s;
  logic [POS_W-1:0]    pos_stepped_s;
  logic [3:0]          idle_signal_s;

  assign accept_s    = (state_r == ST_IDLE) & cmd.cmd_valid;
  assign zero_len_s  = (cmd.cmd_steps == '0);
  assign step_s      = (state_r == ST_RUN) & tick_s & ~abort;
  assign last_step_s = step_s & (steps_left_r == STEP_ONE);

  // Timer is parked at zero in IDLE so a new command always starts a full period
  assign timer_clr_s = (state_r == ST_IDLE) | abort;
  assign timer_run_s = en & (state_r != ST_IDLE);

  assign idx_stepped_s = idx_r + step_delta(idx_r, mode_r, dir_r);
  assign pos_stepped_s = dir_r ? (position_r - POS_ONE) : (position_r + POS_ONE);

`ifdef STEP_HOLD_EN
  assign idle_signal_s = signal_r;
`else
  assign idle_signal_s = 4'b0000;
`endif

  step_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_step_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (timer_clr_s),
    .run    (timer_run_s),
    .period (period_r),
    .tick   (tick_s)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: abort wins over any coincident step or dwell expiry
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && !zero_len_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else if (last_step_s) begin
          state_nxt_s = ST_DWELL;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DWELL: begin
        if (abort || tick_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DWELL;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: next phase index, position, coil pattern and done pulse
  always_comb begin
    idx_nxt_s      = idx_r;
    position_nxt_s = position_r;
    signal_nxt_s   = signal_r;
    done_nxt_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && !zero_len_s) begin
          signal_nxt_s = coil_pattern(idx_r);
        end else begin
          signal_nxt_s = idle_signal_s;
        end
        if (accept_s && zero_len_s) begin
          done_nxt_s = 1'b1;
        end else begin
          done_nxt_s = 1'b0;
        end
      end
      ST_RUN: begin
        if (abort) begin
          done_nxt_s   = 1'b1;
          signal_nxt_s = idle_signal_s;
        end else if (step_s) begin
          idx_nxt_s      = idx_stepped_s;
          position_nxt_s = pos_stepped_s;
          signal_nxt_s   = coil_pattern(idx_stepped_s);
        end else begin
          signal_nxt_s = signal_r;
        end
      end
      ST_DWELL: begin
        if (abort || tick_s) begin
          done_nxt_s   = 1'b1;
          signal_nxt_s = idle_signal_s;
        end else begin
          signal_nxt_s = signal_r;
        end
      end
      default: begin
        signal_nxt_s = 4'b0000;
        done_nxt_s   = 1'b0;
      end
    endcase
  end

  // Command latch: parameters captured once at acceptance, step budget counted down
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_r        <= 1'b0;
      mode_r       <= WAVE;
      steps_left_r <= '0;
      period_r     <= PER_ONE;
    end else if (accept_s) begin
      dir_r        <= cmd.cmd_dir;
      mode_r       <= decode_mode(cmd.cmd_mode);
      steps_left_r <= cmd.cmd_steps;
      period_r     <= (period == '0) ? PER_ONE : period;
    end else if (step_s) begin
      steps_left_r <= steps_left_r - STEP_ONE;
    end else begin
      steps_left_r <= steps_left_r;
    end
  end

  // Registered outputs and phase/position state
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r       <= 3'd0;
      position_r  <= '0;
      signal_r    <= 4'b0000;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      cmd_ready_r <= 1'b1;
    end else begin
      idx_r       <= idx_nxt_s;
      position_r  <= position_nxt_s;
      signal_r    <= signal_nxt_s;
      done_r      <= done_nxt_s;
      busy_r      <= (state_nxt_s != ST_IDLE);
      cmd_ready_r <= (state_nxt_s == ST_IDLE);
    end
  end

  assign busy          = busy_r;
  assign done          = done_r;
  assign position      = position_r;
  assign signal        = signal_r;
  assign cmd.cmd_ready = cmd_ready_r;

endmodule
